writeback_unit: RTL and testbench

- Result-writeback end of the RV32I datapath; the operand-build stage feeds the ALU, and this block takes results back to the register-file write port.
- Accepts one retired instruction per handshake and selects the destination value from the instruction type: ALU result, load data, immediate, PC+imm or PC+4.
- For loads, waits for the data-memory response, then extracts and extends the requested byte/half/word.
- Drives a registered write port (rd_we/rd_waddr/rd_wdata) into the register file.

---
 rtl/writeback_unit.sv | 172 +++++++++++++++++
 tb/tb_writeback_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - RV32I result writeback into the register-file write port
// Optional macro WB_FWD_EN adds the fwd_valid/fwd_addr/fwd_data bypass outputs.
module writeback_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            instr_type,
    input  logic                  is_load,
    input  logic                  is_jalr,
    input  logic                  is_auipc,
    input  logic [2:0]            funct3,
    input  logic [1:0]            byte_off,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       imm,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  rd_we,
    output logic [REG_ADDR_W-1:0] rd_waddr,
    output logic [XLEN-1:0]       rd_wdata,
    output logic                  wb_busy
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [XLEN-1:0]       fwd_data
`endif
);

    localparam logic [3:0] T_R = 4'd0;
    localparam logic [3:0] T_I = 4'd1;
    localparam logic [3:0] T_U = 4'd4;
    localparam logic [3:0] T_J = 4'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [REG_ADDR_W-1:0] lat_rd;
    logic [2:0]            lat_f3;
    logic [1:0]            lat_off;

    logic            load_req;
    logic            sel_we;
    logic [XLEN-1:0] sel_val;
    logic [XLEN-1:0] load_val;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;

    assign load_req = (instr_type == T_I) && is_load;

    // Destination value for non-load instructions; S, B, N and unknown codes never write.
    always_comb begin
        sel_we  = 1'b0;
        sel_val = alu_result;
        case (instr_type)
            T_R: sel_we = 1'b1;
            T_I: begin
                sel_we  = 1'b1;
                sel_val = is_jalr ? pc + XLEN'(4) : alu_result;
            end
            T_U: begin
                sel_we  = 1'b1;
                sel_val = is_auipc ? pc + imm : imm;
            end
            T_J: begin
                sel_we  = 1'b1;
                sel_val = pc + XLEN'(4);
            end
            default: sel_we = 1'b0;
        endcase
    end

    always_comb begin
        byte_lane = mem_rdata[{lat_off, 3'b000} +: 8];
        half_lane = mem_rdata[{lat_off[1], 4'b0000} +: 16];
        case (lat_f3)
            3'b000:  load_val = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            3'b001:  load_val = {{(XLEN-16){half_lane[15]}}, half_lane};
            3'b010:  load_val = mem_rdata;
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_lane};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_lane};
            default: load_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wb_busy   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = load_req ? WAIT_MEM : WRITE;
                end
            end
            WAIT_MEM: begin
                wb_busy = 1'b1;
                if (mem_rvalid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wb_busy   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The write port is loaded on the edge that enters WRITE, so rd_we covers exactly the WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we    <= 1'b0;
            rd_waddr <= '0;
            rd_wdata <= '0;
            lat_rd   <= '0;
            lat_f3   <= '0;
            lat_off  <= '0;
        end else begin
            rd_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (load_req) begin
                            lat_rd  <= rd_addr;
                            lat_f3  <= funct3;
                            lat_off <= byte_off;
                        end else if (sel_we && (rd_addr != '0)) begin
                            rd_we    <= 1'b1;
                            rd_waddr <= rd_addr;
                            rd_wdata <= sel_val;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid && (lat_rd != '0)) begin
                        rd_we    <= 1'b1;
                        rd_waddr <= lat_rd;
                        rd_wdata <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = rd_we && (rd_waddr != '0);
    assign fwd_addr  = fwd_valid ? rd_waddr : '0;
    assign fwd_data  = fwd_valid ? rd_wdata : '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  instr_type = 4'd7;
    logic        is_load = 1'b0;
    logic        is_jalr = 1'b0;
    logic        is_auipc = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [1:0]  byte_off = 2'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] imm = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        wb_busy;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_type(instr_type), .is_load(is_load), .is_jalr(is_jalr), .is_auipc(is_auipc),
        .funct3(funct3), .byte_off(byte_off), .rd_addr(rd_addr),
        .alu_result(alu_result), .pc(pc), .imm(imm),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .wb_busy(wb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the first negedge after the accepting edge.
    task automatic issue(input logic [3:0] t, input logic ld, input logic jr, input logic au,
                         input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] p, input logic [31:0] im);
        instr_type = t; is_load = ld; is_jalr = jr; is_auipc = au;
        funct3 = f3; byte_off = off; rd_addr = rd;
        alu_result = alu; pc = p; imm = im;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic nonload(input string tag, input logic [3:0] t, input logic jr, input logic au,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] p,
                           input logic [31:0] im, input logic [31:0] exp);
        issue(t, 1'b0, jr, au, 3'd0, 2'd0, rd, alu, p, im);
        check({tag, "_we"}, 32'(rd_we), 32'd1);
        check({tag, "_addr"}, 32'(rd_waddr), 32'(rd));
        check({tag, "_data"}, rd_wdata, exp);
        @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic load_seq(input string tag, input logic [2:0] f3, input logic [1:0] off,
                            input logic [4:0] rd, input logic [31:0] data, input logic [31:0] exp);
        issue(4'd1, 1'b1, 1'b0, 1'b0, f3, off, rd, 32'hDEAD_BEEF, 32'h0, 32'h0);
        check({tag, "_wait_busy"}, 32'(wb_busy), 32'd1);
        check({tag, "_wait_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_wait_we"}, 32'(rd_we), 32'd0);
        mem_rdata = data;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check({tag, "_we"}, 32'(rd_we), 32'd1);
        check({tag, "_addr"}, 32'(rd_waddr), 32'(rd));
        check({tag, "_data"}, rd_wdata, exp);
        @(negedge clk);
        check({tag, "_we_off"}, 32'(rd_we), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_we", 32'(rd_we), 32'd0);
        check("rst_addr", 32'(rd_waddr), 32'd0);
        check("rst_data", rd_wdata, 32'd0);
        check("rst_busy", 32'(wb_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        // R-type with latency, ready and hold checks
        issue(4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
        check("r_we", 32'(rd_we), 32'd1);
        check("r_addr", 32'(rd_waddr), 32'd5);
        check("r_data", rd_wdata, 32'h0000_1234);
        check("r_ready_lo", 32'(in_ready), 32'd0);
        check("r_busy", 32'(wb_busy), 32'd1);
        @(negedge clk);
        check("r_ready_hi", 32'(in_ready), 32'd1);
        check("r_we_off", 32'(rd_we), 32'd0);
        check("r_hold", rd_wdata, 32'h0000_1234);

        nonload("auipc", 4'd4, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0000_0100, 32'h0000_3000, 32'h0000_3100);
        nonload("jal_wrap", 4'd5, 1'b0, 1'b0, 5'd1, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000);
        nonload("lui", 4'd4, 1'b0, 1'b0, 5'd2, 32'h0, 32'h0000_0100, 32'hABCD_E000, 32'hABCD_E000);
        nonload("jalr", 4'd1, 1'b1, 1'b0, 5'd31, 32'h1111_1111, 32'h0000_0200, 32'h0, 32'h0000_0204);
        nonload("addi", 4'd1, 1'b0, 1'b0, 5'd8, 32'h8765_4321, 32'h0000_0200, 32'h0, 32'h8765_4321);

        load_seq("lb", 3'b000, 2'd2, 5'd10, 32'h1280_5634, 32'hFFFF_FF80);
        load_seq("lbu", 3'b100, 2'd2, 5'd11, 32'h1280_5634, 32'h0000_0080);
        load_seq("lh", 3'b001, 2'd2, 5'd12, 32'h1280_5634, 32'h0000_1280);
        load_seq("lh0", 3'b001, 2'd0, 5'd13, 32'h1280_F634, 32'hFFFF_F634);
        load_seq("lhu0", 3'b101, 2'd0, 5'd14, 32'h1280_F634, 32'h0000_F634);
        load_seq("lb3", 3'b000, 2'd3, 5'd15, 32'h7F00_0000, 32'h0000_007F);
        load_seq("lw", 3'b010, 2'd3, 5'd16, 32'hCAFE_BABE, 32'hCAFE_BABE);
        load_seq("lill", 3'b011, 2'd0, 5'd17, 32'hFFFF_FFFF, 32'h0000_0000);

        // S-type: no write, data held, ready back 2 cycles after accept
        issue(4'd2, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd9, 32'h5555_5555, 32'h0, 32'h0);
        check("s_we", 32'(rd_we), 32'd0);
        check("s_ready_lo", 32'(in_ready), 32'd0);
        check("s_hold", rd_wdata, 32'h0000_0000);
        @(negedge clk);
        check("s_ready_hi", 32'(in_ready), 32'd1);

        // R-type to x0
        issue(4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'h9999_9999, 32'h0, 32'h0);
        check("x0_we", 32'(rd_we), 32'd0);
        check("x0_busy", 32'(wb_busy), 32'd1);
        @(negedge clk);
        check("x0_ready", 32'(in_ready), 32'd1);
        check("x0_we2", 32'(rd_we), 32'd0);
        check("x0_addr", 32'(rd_waddr), 32'd17);

        // mem_rvalid while idle is ignored
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("idle_rvalid_we", 32'(rd_we), 32'd0);
        check("idle_rvalid_busy", 32'(wb_busy), 32'd0);

        // Reset during WAIT_MEM aborts the load
        issue(4'd1, 1'b1, 1'b0, 1'b0, 3'b010, 2'd0, 5'd6, 32'h0, 32'h0, 32'h0);
        check("rw_pre_busy", 32'(wb_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rw_busy", 32'(wb_busy), 32'd0);
        check("rw_addr", 32'(rd_waddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rw_post_we", 32'(rd_we), 32'd0);
        check("rw_post_ready", 32'(in_ready), 32'd1);
        check("rw_post_busy", 32'(wb_busy), 32'd0);

        // Reset during WRITE drops the strobe
        issue(4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd5, 32'h0000_0077, 32'h0, 32'h0);
        check("rwr_we_pre", 32'(rd_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rwr_we", 32'(rd_we), 32'd0);
        check("rwr_data", rd_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rwr_ready", 32'(in_ready), 32'd1);

        // in_valid activity during WAIT_MEM is ignored until the load retires
        issue(4'd1, 1'b1, 1'b0, 1'b0, 3'b010, 2'd0, 5'd3, 32'h0, 32'h0, 32'h0);
        instr_type = 4'd0; is_load = 1'b0; rd_addr = 5'd4; alu_result = 32'h0000_0055;
        in_valid = 1'b1;
        @(negedge clk);
        check("tog_ready", 32'(in_ready), 32'd0);
        check("tog_we", 32'(rd_we), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("tog_ld_we", 32'(rd_we), 32'd1);
        check("tog_ld_addr", 32'(rd_waddr), 32'd3);
        check("tog_ld_data", rd_wdata, 32'hCAFE_F00D);
        check("tog_ld_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("tog_idle_ready", 32'(in_ready), 32'd1);
        check("tog_idle_we", 32'(rd_we), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("tog_r_we", 32'(rd_we), 32'd1);
        check("tog_r_addr", 32'(rd_waddr), 32'd4);
        check("tog_r_data", rd_wdata, 32'h0000_0055);
        @(negedge clk);
        check("tog_r_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
